// File: rtl/bp_pht_scheduler.sv
// ============================================================================
//  bp_pht_scheduler : gshare PHT port scheduler (lookups, buffered training,
//                     post-reset clear sweep) for a single-ported 2-bit table.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bp_pht_scheduler #(
    parameter int          IDX_W        = 8,
    parameter int          UPD_DEPTH    = 4,
    parameter int          STARVE_LIMIT = 3,
    parameter logic [1:0]  INIT_VALUE   = 2'b00
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lookup_valid,
    input  logic [63:0]      lookup_ip,
    output logic             lookup_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_index,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             pht_en,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_addr,
    output logic [1:0]       pht_wdata,
    input  logic [1:0]       pht_rdata
);

    localparam int c_PTR_W = (UPD_DEPTH > 2) ? $clog2(UPD_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 2);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UPD_WR = 2'd2
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_sweep;
    logic [IDX_W-1:0]    r_fifo_idx [UPD_DEPTH];
    logic                r_fifo_tkn [UPD_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]    r_ghr;
    logic [c_STV_W-1:0]  r_starve;
    logic                r_pred_valid;
    logic [IDX_W-1:0]    r_pred_index;

    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [IDX_W-1:0]    w_head_idx;
    logic                w_head_tkn;
    logic [IDX_W-1:0]    w_lookup_idx;
    logic                w_upd_sel;
    logic                w_lookup_go;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_trained;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_CNT_W'(UPD_DEPTH));
    assign w_head_idx   = r_fifo_idx[r_rd_ptr];
    assign w_head_tkn   = r_fifo_tkn[r_rd_ptr];
    assign w_lookup_idx = lookup_ip[IDX_W+1:2] ^ r_ghr;

    // An update wins the port when idle, when the FIFO is about to back-pressure,
    // or when lookups have held it off for STARVE_LIMIT grants.
    assign w_upd_sel = !w_fifo_empty &&
                       (!lookup_valid || w_fifo_full ||
                        (r_starve >= c_STV_W'(STARVE_LIMIT)));

    // Combinational handshakes are gated by reset_n so nothing leaks while in reset.
    assign lookup_ready = reset_n && (r_state == ST_RUN) && !w_upd_sel;
    assign upd_ready    = reset_n && (r_state != ST_INIT) && !w_fifo_full;
    assign w_lookup_go  = lookup_valid && lookup_ready;
    assign w_push       = upd_valid && upd_ready;
    assign w_pop        = reset_n && (r_state == ST_UPD_WR);

    assign pred_valid   = r_pred_valid;
    assign pred_index   = r_pred_index;
    assign pred_taken   = r_pred_valid & pht_rdata[1];

    always_comb begin
        w_trained = pht_rdata;
        if (w_head_tkn) begin
            if (pht_rdata != 2'd3) begin
                w_trained = pht_rdata + 2'd1;
            end
        end else begin
            if (pht_rdata != 2'd0) begin
                w_trained = pht_rdata - 2'd1;
            end
        end
    end

    always_comb begin
        pht_en    = 1'b0;
        pht_we    = 1'b0;
        pht_addr  = '0;
        pht_wdata = 2'b00;
        if (reset_n) begin
            case (r_state)
                ST_INIT: begin
                    pht_en    = 1'b1;
                    pht_we    = 1'b1;
                    pht_addr  = r_sweep;
                    pht_wdata = INIT_VALUE;
                end
                ST_RUN: begin
                    if (w_upd_sel) begin
                        pht_en   = 1'b1;
                        pht_addr = w_head_idx;
                    end else if (lookup_valid) begin
                        pht_en   = 1'b1;
                        pht_addr = w_lookup_idx;
                    end
                end
                ST_UPD_WR: begin
                    pht_en    = 1'b1;
                    pht_we    = 1'b1;
                    pht_addr  = w_head_idx;
                    pht_wdata = w_trained;
                end
                default: begin
                    pht_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_INIT;
            r_sweep      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ghr        <= '0;
            r_starve     <= '0;
            r_pred_valid <= 1'b0;
            r_pred_index <= '0;
        end else begin
            r_pred_valid <= w_lookup_go;
            if (w_lookup_go) begin
                r_pred_index <= w_lookup_idx;
            end

            if (w_push) begin
                r_fifo_idx[r_wr_ptr] <= upd_index;
                r_fifo_tkn[r_wr_ptr] <= upd_taken;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
                r_ghr                <= {r_ghr[IDX_W-2:0], upd_taken};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end

            case (r_state)
                ST_INIT: begin
                    r_sweep <= r_sweep + 1'b1;
                    if (r_sweep == {IDX_W{1'b1}}) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_upd_sel) begin
                        r_state  <= ST_UPD_WR;
                        r_starve <= '0;
                    end else if (!w_fifo_empty &&
                                 (r_starve < c_STV_W'(STARVE_LIMIT))) begin
                        r_starve <= r_starve + c_STV_W'(1);
                    end
                end
                ST_UPD_WR: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_pht_scheduler.sv
// ============================================================================
//  tb_bp_pht_scheduler : directed bench with PHT memory model and prediction
//                        scoreboard for bp_pht_scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bp_pht_scheduler;

    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             lookup_valid;
    logic [63:0]      lookup_ip;
    logic             lookup_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_index;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             upd_ready;
    logic             pht_en;
    logic             pht_we;
    logic [IDX_W-1:0] pht_addr;
    logic [1:0]       pht_wdata;
    logic [1:0]       pht_rdata;

    bp_pht_scheduler #(
        .IDX_W(IDX_W), .UPD_DEPTH(4), .STARVE_LIMIT(3), .INIT_VALUE(2'b00)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_ip(lookup_ip), .lookup_ready(lookup_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_index(pred_index),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_ready(upd_ready),
        .pht_en(pht_en), .pht_we(pht_we), .pht_addr(pht_addr),
        .pht_wdata(pht_wdata), .pht_rdata(pht_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] idx;
        logic       tkn;
    } exp_t;

    logic [1:0] mem       [256];
    logic [1:0] model_cnt [256];
    logic [7:0] model_ghr;
    exp_t       sb [$];
    logic [1:0] wlog [$];
    exp_t       e_pop;
    logic [7:0] m_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Single-ported PHT: read data appears the cycle after a read; reset scrambles it.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 2'b11;
        end else if (pht_en) begin
            if (pht_we) begin
                mem[pht_addr] <= pht_wdata;
                if (pht_addr == 8'h10) wlog.push_back(pht_wdata);
            end else begin
                pht_rdata <= mem[pht_addr];
            end
        end
    end

    // Reference predictor model and prediction scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
            model_ghr = 8'h00;
            for (int i = 0; i < 256; i++) model_cnt[i] = 2'b00;
        end else begin
            if (pred_valid) begin
                if (sb.size() == 0) begin
                    check("pred_unexpected", 64'(pred_valid), 64'(0));
                end else begin
                    e_pop = sb.pop_front();
                    check("pred_index", 64'(pred_index), 64'(e_pop.idx));
                    check("pred_taken", 64'(pred_taken), 64'(e_pop.tkn));
                end
            end
            if (lookup_valid && lookup_ready) begin
                m_idx = lookup_ip[9:2] ^ model_ghr;
                sb.push_back({m_idx, model_cnt[m_idx][1]});
            end
            if (upd_valid && upd_ready) begin
                if (upd_taken) begin
                    if (model_cnt[upd_index] != 2'd3) model_cnt[upd_index] = model_cnt[upd_index] + 2'd1;
                end else begin
                    if (model_cnt[upd_index] != 2'd0) model_cnt[upd_index] = model_cnt[upd_index] - 2'd1;
                end
                model_ghr = {model_ghr[6:0], upd_taken};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_check(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            check("sweep", 64'({pht_en, pht_we, pht_addr, pht_wdata, lookup_ready, upd_ready}),
                  64'({1'b1, 1'b1, 8'(k), 2'b00, 1'b0, 1'b0}));
            tick();
        end
    endtask

    task automatic sweep_done();
        int nz;
        #1;
        check("run_ready", 64'({lookup_ready, upd_ready}), 64'(2'b11));
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != 2'b00) nz++;
        check("sweep_mem_nonzero", 64'(nz), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; lookup_valid = 1'b0; lookup_ip = 64'h0;
        upd_valid = 1'b0; upd_index = 8'h00; upd_taken = 1'b0;
        repeat (3) tick();
        #1;
        check("reset_outputs",
              64'({lookup_ready, upd_ready, pht_en, pred_valid, pred_taken, pred_index}), 64'(0));

        // Clear sweep after reset
        reset_n = 1'b1;
        sweep_check(256);
        sweep_done();

        // First lookup, GHR = 0
        lookup_valid = 1'b1; lookup_ip = 64'h40;
        #1;
        check("lookup_read", 64'({pht_en, pht_we, pht_addr}), 64'({1'b1, 1'b0, 8'h10}));
        tick();
        lookup_valid = 1'b0;
        #1;
        check("lookup_pred", 64'({pred_valid, pred_taken, pred_index}), 64'({1'b1, 1'b0, 8'h10}));
        tick();

        // Saturating training of index 0x10
        wlog.delete();
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1'b1; upd_index = 8'h10; upd_taken = 1'b1;
            #1;
            check("train_upd_ready", 64'(upd_ready), 64'(1));
            tick();
        end
        upd_valid = 1'b0;
        repeat (12) tick();
        check("train_write_count", 64'(wlog.size()), 64'(4));
        check("train_write_seq", 64'({wlog[0], wlog[1], wlog[2], wlog[3]}), 64'(8'b01_10_11_11));

        // GHR now 0x0F: ip 0x7C maps to 0x10, ip 0 maps to 0x0F
        lookup_valid = 1'b1; lookup_ip = 64'h7C;
        #1;
        check("ghr_lookup_addr", 64'(pht_addr), 64'(8'h10));
        tick();
        lookup_ip = 64'h0;
        #1;
        check("ghr_lookup_addr2", 64'(pht_addr), 64'(8'h0F));
        tick();
        lookup_valid = 1'b0;
        tick(); tick();

        // Starvation limit with a continuous lookup stream
        lookup_valid = 1'b1; lookup_ip = 64'h0;
        upd_valid = 1'b1; upd_index = 8'h80; upd_taken = 1'b1;
        for (int k = 0; k < 7; k++) begin
            logic [6:0] pat;
            pat = 7'b1111001;
            #1;
            check("starve_lookup_ready", 64'(lookup_ready), 64'(pat[6-k]));
            if (k == 4) check("starve_upd_read", 64'({pht_en, pht_we, pht_addr}), 64'({1'b1, 1'b0, 8'h80}));
            if (k == 5) check("starve_upd_write", 64'({pht_en, pht_we, pht_addr, pht_wdata}),
                              64'({1'b1, 1'b1, 8'h80, 2'b01}));
            tick();
            upd_valid = 1'b0;
        end
        lookup_valid = 1'b0;
        tick(); tick();

        // FIFO fills behind streaming lookups
        lookup_valid = 1'b1; lookup_ip = 64'h0;
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1'b1; upd_index = 8'(8'h81 + k); upd_taken = 1'b0;
            #1;
            check("full_upd_ready", 64'(upd_ready), 64'(1));
            tick();
        end
        upd_valid = 1'b0;
        #1;
        check("full_forces_update", 64'({upd_ready, lookup_ready, pht_en, pht_we, pht_addr}),
              64'({1'b0, 1'b0, 1'b1, 1'b0, 8'h81}));
        tick();
        lookup_valid = 1'b0;
        repeat (14) tick();
        check("full_drained_ready", 64'({lookup_ready, upd_ready}), 64'(2'b11));

        // Reset during UPD_WR
        upd_valid = 1'b1; upd_index = 8'h90; upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        #1;
        check("abort_upd_read", 64'({pht_en, pht_we, pht_addr}), 64'({1'b1, 1'b0, 8'h90}));
        tick();
        #1;
        check("abort_upd_wr_state", 64'({pht_en, pht_we, pht_addr}), 64'({1'b1, 1'b1, 8'h90}));
        reset_n = 1'b0;
        #1;
        check("abort_no_write", 64'(pht_en), 64'(0));
        tick(); tick();
        reset_n = 1'b1;

        // Reset during the sweep
        sweep_check(100);
        reset_n = 1'b0;
        #1;
        check("sweep_abort_no_write", 64'(pht_en), 64'(0));
        tick();
        reset_n = 1'b1;
        sweep_check(256);
        sweep_done();

        // FIFO empty and GHR cleared after reset
        lookup_valid = 1'b1; lookup_ip = 64'h40;
        #1;
        check("post_reset_lookup", 64'({lookup_ready, pht_addr}), 64'({1'b1, 8'h10}));
        tick();
        lookup_valid = 1'b0;
        tick(); tick();

        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
